// File: rtl/main_mem_ctrl_if.sv
// Request/response bus between the cache bus and the main-memory controller.
// Signal names carry the controller's point of view (_i = into the controller,
// _o = out of the controller).
//   mem_ready_o  : controller can take a request beat this cycle
//   mem_valid_i  : request beat valid
//   mem_we_i     : 1 = write beat, 0 = read beat
//   mem_addr_i   : byte address of the block (first beat only)
//   mem_wdata_i  : write data, word 0 in the LSBs
//   mem_valid_o  : read-response beat valid (no backpressure)
//   mem_data_o   : read-response data
// Modports: master = cache-bus side, slave = controller side.
interface main_mem_ctrl_if #(
    parameter int dma_data_width_p = 1
);
    logic                            mem_ready_o;
    logic                            mem_valid_i;
    logic                            mem_we_i;
    logic [31:0]                     mem_addr_i;
    logic [dma_data_width_p*32-1:0]  mem_wdata_i;
    logic                            mem_valid_o;
    logic [dma_data_width_p*32-1:0]  mem_data_o;

    modport master (
        input  mem_ready_o, mem_valid_o, mem_data_o,
        output mem_valid_i, mem_we_i, mem_addr_i, mem_wdata_i
    );

    modport slave (
        output mem_ready_o, mem_valid_o, mem_data_o,
        input  mem_valid_i, mem_we_i, mem_addr_i, mem_wdata_i
    );
endinterface

// File: rtl/main_mem_ctrl.sv
// Burst-capable main-memory model/controller sitting directly below the cache bus.
// One transaction at a time: BEATS request beats (read or write) are taken under
// mem_ready_o backpressure; read data returns as BEATS consecutive response beats,
// the first one latency_p cycles after the edge that took the last request beat.
// Ports:
//   clk_i     : clock, rising edge
//   nreset_i  : asynchronous active-low reset (storage array is not reset)
//   bus       : main_mem_ctrl_if.slave request/response bus
module main_mem_ctrl #(
    parameter int block_width_p    = 4,
    parameter int dma_data_width_p = 1,
    parameter int mem_words_p      = 1024,
    parameter int latency_p        = 4
) (
    input  logic           clk_i,
    input  logic           nreset_i,
    main_mem_ctrl_if.slave bus
);
    localparam int beats_lp = block_width_p / dma_data_width_p;
    localparam int bcw_lp   = $clog2(beats_lp) + 1;
    localparam int lcw_lp   = $clog2(latency_p) + 1;
    localparam int aw_lp    = $clog2(mem_words_p);
    localparam int dw_lp    = dma_data_width_p * 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        RD_REQ = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t              state_r;
    logic [bcw_lp-1:0]   beat_cnt_r;
    logic [lcw_lp-1:0]   lat_cnt_r;
    logic [aw_lp-1:0]    base_r;
    logic                we_r;
    logic                ready_r;
    logic                valid_r;
    logic [dw_lp-1:0]    data_r;
    logic [31:0]         mem_r [mem_words_p];

    logic                accept_s;
    logic                last_req_s;
    logic                wr_en_s;
    logic [aw_lp-1:0]    wr_addr_s;
    logic [aw_lp-1:0]    rd_addr_s;
    logic [dw_lp-1:0]    rd_data_s;

    // Word index of the block: drop byte offset, clear in-block bits, wrap to the array depth.
    function automatic logic [aw_lp-1:0] block_base(input logic [31:0] addr);
        logic [aw_lp-1:0] word_v;
        word_v = addr[aw_lp+1:2];
        return word_v & ~aw_lp'(block_width_p - 1);
    endfunction

    // First word covered by beat idx of the block starting at base.
    function automatic logic [aw_lp-1:0] beat_addr(input logic [aw_lp-1:0]  base,
                                                   input logic [bcw_lp-1:0] idx);
        logic [31:0] sum_v;
        sum_v = 32'(base) + 32'(idx) * 32'(dma_data_width_p);
        return sum_v[aw_lp-1:0];
    endfunction

    assign accept_s   = bus.mem_valid_i & ready_r;
    // beat_cnt is 0 in IDLE, so this also flags a single-beat transaction's only beat.
    assign last_req_s = (beat_cnt_r == bcw_lp'(beats_lp - 1));

    // Write port: beat 0 uses the incoming address, later beats the latched base.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = '0;
        if (accept_s && (state_r == IDLE) && bus.mem_we_i) begin
            wr_en_s   = 1'b1;
            wr_addr_s = beat_addr(block_base(bus.mem_addr_i), bcw_lp'(0));
        end else if (accept_s && (state_r == WR)) begin
            wr_en_s   = 1'b1;
            wr_addr_s = beat_addr(base_r, beat_cnt_r);
        end else begin
            wr_en_s   = 1'b0;
            wr_addr_s = '0;
        end
    end

    // Read port: fetch the beat that is registered onto the bus at the next edge.
    always_comb begin
        rd_data_s = '0;
        if (state_r == RESP) begin
            rd_addr_s = beat_addr(base_r, beat_cnt_r);
        end else begin
            rd_addr_s = beat_addr(base_r, bcw_lp'(0));
        end
        for (int j = 0; j < dma_data_width_p; j++) begin
            rd_data_s[j*32 +: 32] = mem_r[rd_addr_s + aw_lp'(j)];
        end
    end

    // Storage array; intentionally left out of reset so committed data survives it.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            for (int j = 0; j < dma_data_width_p; j++) begin
                mem_r[wr_addr_s + aw_lp'(j)] <= bus.mem_wdata_i[j*32 +: 32];
            end
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_r    <= IDLE;
            beat_cnt_r <= '0;
            lat_cnt_r  <= '0;
            base_r     <= '0;
            we_r       <= 1'b0;
            ready_r    <= 1'b0;
            valid_r    <= 1'b0;
            data_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                    if (accept_s) begin
                        base_r    <= block_base(bus.mem_addr_i);
                        we_r      <= bus.mem_we_i;
                        lat_cnt_r <= '0;
                        if (last_req_s) begin
                            beat_cnt_r <= '0;
                            state_r    <= bus.mem_we_i ? IDLE : WAIT;
                            ready_r    <= bus.mem_we_i;
                        end else begin
                            beat_cnt_r <= bcw_lp'(1);
                            state_r    <= bus.mem_we_i ? WR : RD_REQ;
                        end
                    end
                end
                WR: begin
                    if (accept_s) begin
                        if (last_req_s) begin
                            beat_cnt_r <= '0;
                            state_r    <= IDLE;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + bcw_lp'(1);
                        end
                    end
                end
                RD_REQ: begin
                    if (accept_s) begin
                        if (last_req_s) begin
                            beat_cnt_r <= '0;
                            lat_cnt_r  <= '0;
                            ready_r    <= 1'b0;
                            state_r    <= WAIT;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + bcw_lp'(1);
                        end
                    end
                end
                WAIT: begin
                    // Leaving on the latency_p-th edge after the last request beat
                    // puts beat 0 on the bus exactly latency_p cycles later.
                    if (lat_cnt_r == lcw_lp'(latency_p - 1)) begin
                        valid_r    <= 1'b1;
                        data_r     <= rd_data_s;
                        beat_cnt_r <= bcw_lp'(1);
                        state_r    <= RESP;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + lcw_lp'(1);
                    end
                end
                RESP: begin
                    if (beat_cnt_r == bcw_lp'(beats_lp)) begin
                        valid_r    <= 1'b0;
                        beat_cnt_r <= '0;
                        ready_r    <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        valid_r    <= 1'b1;
                        data_r     <= rd_data_s;
                        beat_cnt_r <= beat_cnt_r + bcw_lp'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    beat_cnt_r <= '0;
                    ready_r    <= 1'b0;
                    valid_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_ready_o = ready_r;
    assign bus.mem_valid_o = valid_r;
    assign bus.mem_data_o  = data_r;

    main_mem_ctrl_chk u_chk (
        .clk_i       (clk_i),
        .nreset_i    (nreset_i),
        .first_beat  (accept_s && (state_r == IDLE)),
        .next_beat   (accept_s && ((state_r == WR) || (state_r == RD_REQ))),
        .we_in       (bus.mem_we_i),
        .we_latched  (we_r),
        .addr_in     (bus.mem_addr_i)
    );
endmodule

// Protocol checker: request direction must not change inside a transaction and
// the first beat must carry a known address/direction.
module main_mem_ctrl_chk (
    input logic        clk_i,
    input logic        nreset_i,
    input logic        first_beat,
    input logic        next_beat,
    input logic        we_in,
    input logic        we_latched,
    input logic [31:0] addr_in
);
    we_stable_a: assert property (@(posedge clk_i) disable iff (!nreset_i)
        next_beat |-> (we_in == we_latched))
        else $error("main_mem_ctrl: mem_we_i changed within a transaction");

    first_known_a: assert property (@(posedge clk_i) disable iff (!nreset_i)
        first_beat |-> !$isunknown({we_in, addr_in}))
        else $error("main_mem_ctrl: unknown address or direction on first beat");
endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed self-checking bench for main_mem_ctrl.
// dut_a: 4 single-word beats, latency 4. dut_b: one 128-bit beat, latency 1.
module tb_main_mem_ctrl;
    localparam int LAT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    main_mem_ctrl_if #(.dma_data_width_p(1)) bus_a ();
    main_mem_ctrl_if #(.dma_data_width_p(4)) bus_b ();

    main_mem_ctrl #(.block_width_p(4), .dma_data_width_p(1), .mem_words_p(1024), .latency_p(4)) dut_a (
        .clk_i    (clk),
        .nreset_i (rst_n),
        .bus      (bus_a)
    );

    main_mem_ctrl #(.block_width_p(4), .dma_data_width_p(4), .mem_words_p(1024), .latency_p(1)) dut_b (
        .clk_i    (clk),
        .nreset_i (rst_n),
        .bus      (bus_b)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request beat on bus_a and wait (bounded) until it is taken.
    task automatic send_beat(input logic we, input logic [31:0] addr, input logic [31:0] data);
        logic got;
        int   n;
        bus_a.mem_valid_i = 1'b1;
        bus_a.mem_we_i    = we;
        bus_a.mem_addr_i  = addr;
        bus_a.mem_wdata_i = data;
        got = 1'b0;
        n   = 0;
        while (!got && n < 20) begin
            got = bus_a.mem_ready_o;
            @(posedge clk); #1;
            n++;
        end
        chk("beat_accept", 128'(got), 128'(1'b1));
    endtask

    task automatic wr_block(input logic [31:0] addr, input logic [31:0] first);
        for (int k = 0; k < 4; k++) send_beat(1'b1, addr, first + 32'(k));
        bus_a.mem_valid_i = 1'b0;
    endtask

    task automatic rd_block(input logic [31:0] addr);
        for (int k = 0; k < 4; k++) send_beat(1'b0, addr, 32'h0);
        bus_a.mem_valid_i = 1'b0;
    endtask

    // Called right after the edge that took the last read beat; expects words first..first+3.
    task automatic expect_resp(input string tag, input logic [31:0] first);
        for (int c = 1; c <= LAT + 3; c++) begin
            @(posedge clk); #1;
            chk({tag, "_valid"}, 128'(bus_a.mem_valid_o), 128'(c >= LAT));
            chk({tag, "_ready_busy"}, 128'(bus_a.mem_ready_o), 128'(1'b0));
            if (c >= LAT) chk({tag, "_data"}, 128'(bus_a.mem_data_o), 128'(first + 32'(c - LAT)));
        end
        @(posedge clk); #1;
        chk({tag, "_valid_end"}, 128'(bus_a.mem_valid_o), 128'(1'b0));
        chk({tag, "_data_hold"}, 128'(bus_a.mem_data_o), 128'(first + 32'd3));
        chk({tag, "_ready_end"}, 128'(bus_a.mem_ready_o), 128'(1'b1));
    endtask

    logic [0:6]   pat_v;
    logic [127:0] wide_v;

    initial begin
        bus_a.mem_valid_i = 1'b0;
        bus_a.mem_we_i    = 1'b0;
        bus_a.mem_addr_i  = 32'h0;
        bus_a.mem_wdata_i = 32'h0;
        bus_b.mem_valid_i = 1'b0;
        bus_b.mem_we_i    = 1'b0;
        bus_b.mem_addr_i  = 32'h0;
        bus_b.mem_wdata_i = 128'h0;

        // Reset: outputs cleared asynchronously, ready rises after release.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 128'(bus_a.mem_ready_o), 128'(1'b0));
        chk("rst_valid", 128'(bus_a.mem_valid_o), 128'(1'b0));
        chk("rst_data",  128'(bus_a.mem_data_o),  128'(32'h0));
        @(posedge clk); #1;
        chk("rst_hold_ready", 128'(bus_a.mem_ready_o), 128'(1'b0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready_a", 128'(bus_a.mem_ready_o), 128'(1'b1));
        chk("post_rst_ready_b", 128'(bus_b.mem_ready_o), 128'(1'b1));

        // 1: write A0..A3 at 0x40, read it back immediately.
        wr_block(32'h40, 32'hA0);
        rd_block(32'h40);
        expect_resp("rd40", 32'hA0);

        // 2: read request beats with gaps; latency counts from the 4th accepted beat.
        pat_v = 7'b1001101;
        for (int i = 0; i < 7; i++) begin
            bus_a.mem_valid_i = pat_v[i];
            bus_a.mem_we_i    = 1'b0;
            bus_a.mem_addr_i  = 32'h40;
            chk("gap_ready", 128'(bus_a.mem_ready_o), 128'(1'b1));
            @(posedge clk); #1;
            chk("gap_no_early", 128'(bus_a.mem_valid_o), 128'(1'b0));
        end
        bus_a.mem_valid_i = 1'b0;
        expect_resp("gap", 32'hA0);

        // 3: a write beat held during WAIT/RESP must be ignored; 0x44 maps to block 0x40.
        wr_block(32'h80, 32'hB0);
        rd_block(32'h44);
        bus_a.mem_valid_i = 1'b1;
        bus_a.mem_we_i    = 1'b1;
        bus_a.mem_addr_i  = 32'h80;
        bus_a.mem_wdata_i = 32'hDEADBEEF;
        expect_resp("rd44_busy", 32'hA0);
        bus_a.mem_valid_i = 1'b0;
        bus_a.mem_we_i    = 1'b0;
        rd_block(32'h80);
        expect_resp("rd80", 32'hB0);

        // 4: address wraps modulo the array depth.
        rd_block(32'h40 + 32'd4096);
        expect_resp("wrap", 32'hA0);

        // 5: reset pulse during response beat 2.
        rd_block(32'h40);
        for (int c = 1; c <= LAT + 2; c++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_valid", 128'(bus_a.mem_valid_o), 128'(1'b1));
        chk("pre_rst_data",  128'(bus_a.mem_data_o),  128'(32'hA2));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(bus_a.mem_valid_o), 128'(1'b0));
        chk("mid_rst_ready", 128'(bus_a.mem_ready_o), 128'(1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_rst_ready", 128'(bus_a.mem_ready_o), 128'(1'b1));
        chk("after_rst_valid", 128'(bus_a.mem_valid_o), 128'(1'b0));
        rd_block(32'h80);
        expect_resp("rd80_after_rst", 32'hB0);

        // 6: single 128-bit beat, latency 1.
        wide_v = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
        bus_b.mem_valid_i = 1'b1;
        bus_b.mem_we_i    = 1'b1;
        bus_b.mem_addr_i  = 32'h100;
        bus_b.mem_wdata_i = wide_v;
        chk("b_wr_ready", 128'(bus_b.mem_ready_o), 128'(1'b1));
        @(posedge clk); #1;
        chk("b_rd_ready", 128'(bus_b.mem_ready_o), 128'(1'b1));
        bus_b.mem_we_i = 1'b0;
        @(posedge clk); #1;
        bus_b.mem_valid_i = 1'b0;
        chk("b_no_early", 128'(bus_b.mem_valid_o), 128'(1'b0));
        chk("b_busy",     128'(bus_b.mem_ready_o), 128'(1'b0));
        @(posedge clk); #1;
        chk("b_valid", 128'(bus_b.mem_valid_o), 128'(1'b1));
        chk("b_data",  bus_b.mem_data_o, wide_v);
        @(posedge clk); #1;
        chk("b_valid_end", 128'(bus_b.mem_valid_o), 128'(1'b0));
        chk("b_data_hold", bus_b.mem_data_o, wide_v);
        chk("b_ready_end", 128'(bus_b.mem_ready_o), 128'(1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
